// File: rtl/pulse_seq_engine.sv
// pulse_seq_engine
// Table-driven pulse sequencer. A free-running period counter on clk_pll
// defines each shot; at every wrap the sequencer latches its configuration
// and either replays the active segment table (RUN -> HOLD), stays IDLE, or
// enters CW mode. Two table banks: software writes the shadow bank and a swap
// request flips the banks at the next wrap.
//
// Ports
//   clk_pll                 200 MHz PLL clock
//   reset                   synchronous, active-low reset
//   enable, cw_mode         run / CW select, sampled at wrap
//   period                  counter runs 0..period (used live)
//   sync_len                scope trigger width in cycles
//   n_seg                   valid segments in the active bank (clamped to DEPTH)
//   loop_start/end/count    repeat region and number of passes
//   pre_att, post_att       attenuator settings
//   wr_en/addr/dur/chan/win shadow-bank segment write port
//   swap_req / swap_ack     bank swap request / pulse in the wrap cycle it happens
//   sync_on, chan_on        scope trigger and switch outputs (registered)
//   Att1, Att3              attenuator outputs (registered)
//   seq_active              high while a segment is executing (registered)
module pulse_seq_engine #(
    parameter int CNT_W = 32,
    parameter int DEPTH = 16,
    parameter int AW    = 4,
    parameter int NCH   = 2,
    parameter int ATT_W = 7
) (
    input  logic             clk_pll,
    input  logic             reset,
    input  logic             enable,
    input  logic             cw_mode,
    input  logic [CNT_W-1:0] period,
    input  logic [CNT_W-1:0] sync_len,
    input  logic [AW:0]      n_seg,
    input  logic [AW-1:0]    loop_start,
    input  logic [AW-1:0]    loop_end,
    input  logic [7:0]       loop_count,
    input  logic [ATT_W-1:0] pre_att,
    input  logic [ATT_W-1:0] post_att,
    input  logic             wr_en,
    input  logic [AW-1:0]    wr_addr,
    input  logic [CNT_W-1:0] wr_dur,
    input  logic [NCH-1:0]   wr_chan,
    input  logic             wr_win,
    input  logic             swap_req,
    output logic             swap_ack,
    output logic             sync_on,
    output logic [NCH-1:0]   chan_on,
    output logic [ATT_W-1:0] Att1,
    output logic [ATT_W-1:0] Att3,
    output logic             seq_active
);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_HOLD, S_CW} state_t;

    localparam logic [AW:0] DEPTH_C = (AW+1)'(DEPTH);

    // Segment table: both banks in one array, bank select is the address MSB.
    logic [CNT_W-1:0] r_dur_mem  [0:2*DEPTH-1];
    logic [NCH-1:0]   r_chan_mem [0:2*DEPTH-1];
    logic             r_win_mem  [0:2*DEPTH-1];

    state_t           r_state, w_state_next;
    logic [CNT_W-1:0] r_cnt, w_cnt_next;
    logic [CNT_W-1:0] r_timer, w_timer_next;
    logic [CNT_W-1:0] r_sync_len, w_sync_len_next, w_cw_thr;
    logic [AW-1:0]    r_seg, w_seg_next;
    logic [AW-1:0]    r_lstart, w_lstart_next, r_lend, w_lend_next;
    logic [AW:0]      r_nseg, w_nseg_next, w_nseg_clamp;
    logic [7:0]       r_iter, w_iter_next, r_lcount, w_lcount_next;
    logic             r_bank, w_bank_next, r_pend, w_pend_next;
    logic             w_wrap, w_swap, w_load, w_loop_back;
    logic [CNT_W-1:0] w_ld_dur;
    logic [NCH-1:0]   w_cur_chan;
    logic             w_cur_win;

    logic             r_sync, r_active;
    logic [NCH-1:0]   r_chan;
    logic [ATT_W-1:0] r_att1, r_att3;

    // >= rather than == so a live period reduced below the counter still
    // produces a clean wrap instead of a silent restart.
    assign w_wrap       = (r_cnt >= period);
    assign w_cnt_next   = w_wrap ? '0 : r_cnt + CNT_W'(1);
    assign w_nseg_clamp = (n_seg > DEPTH_C) ? DEPTH_C : n_seg;
    assign w_swap       = w_wrap & (r_pend | swap_req);
    assign w_bank_next  = r_bank ^ w_swap;
    assign w_pend_next  = ~w_wrap & (r_pend | swap_req);

    assign w_nseg_next     = w_wrap ? w_nseg_clamp : r_nseg;
    assign w_lstart_next   = w_wrap ? loop_start   : r_lstart;
    assign w_lend_next     = w_wrap ? loop_end     : r_lend;
    assign w_lcount_next   = w_wrap ? loop_count   : r_lcount;
    assign w_sync_len_next = w_wrap ? sync_len     : r_sync_len;
    assign w_cw_thr        = (period >= w_sync_len_next) ? period - w_sync_len_next : '0;

    // Ack is decoded in the wrap cycle itself so it lines up with counter==period.
    assign swap_ack = reset & w_swap;

    assign w_cur_chan = r_chan_mem[{r_bank, r_seg}];
    assign w_cur_win  = r_win_mem[{r_bank, r_seg}];

    // Loop back only for a well-formed region that lies inside the table.
    assign w_loop_back = (r_seg == r_lend) && (r_lstart <= r_lend) &&
                         ({1'b0, r_lend} < r_nseg) &&
                         (({1'b0, r_iter} + 9'd1) < {1'b0, r_lcount});

    // Writes go to the bank that is shadow after this edge, so a write in a
    // swapping wrap cycle lands in the bank being retired, never the new one.
    always_ff @(posedge clk_pll) begin
        if (wr_en) begin
            r_dur_mem[{~w_bank_next, wr_addr}]  <= wr_dur;
            r_chan_mem[{~w_bank_next, wr_addr}] <= wr_chan;
            r_win_mem[{~w_bank_next, wr_addr}]  <= wr_win;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_seg_next   = r_seg;
        w_iter_next  = r_iter;
        w_timer_next = r_timer;
        w_load       = 1'b0;
        if (w_wrap) begin
            if (cw_mode) begin
                w_state_next = S_CW;
            end else if (enable && (w_nseg_clamp != '0)) begin
                w_state_next = S_RUN;
                w_seg_next   = '0;
                w_iter_next  = '0;
                w_load       = 1'b1;
            end else begin
                w_state_next = S_IDLE;
            end
        end else if (r_state == S_RUN) begin
            if (r_timer <= CNT_W'(1)) begin
                if (w_loop_back) begin
                    w_seg_next  = r_lstart;
                    w_iter_next = r_iter + 8'd1;
                    w_load      = 1'b1;
                end else if (((AW+1)'(r_seg) + (AW+1)'(1)) < r_nseg) begin
                    w_seg_next = r_seg + AW'(1);
                    w_load     = 1'b1;
                end else begin
                    w_state_next = S_HOLD;
                end
            end else begin
                w_timer_next = r_timer - CNT_W'(1);
            end
        end
        // Duration of the segment about to start, from the bank active after
        // this edge; a zero duration still occupies one cycle.
        w_ld_dur = r_dur_mem[{w_bank_next, w_seg_next}];
        if (w_load) begin
            w_timer_next = (w_ld_dur == '0) ? CNT_W'(1) : w_ld_dur;
        end
    end

    always_ff @(posedge clk_pll) begin
        if (!reset) begin
            r_state    <= S_IDLE;
            r_cnt      <= '0;
            r_timer    <= '0;
            r_seg      <= '0;
            r_iter     <= '0;
            r_bank     <= 1'b0;
            r_pend     <= 1'b0;
            r_nseg     <= '0;
            r_lstart   <= '0;
            r_lend     <= '0;
            r_lcount   <= '0;
            r_sync_len <= '0;
        end else begin
            r_state    <= w_state_next;
            r_cnt      <= w_cnt_next;
            r_timer    <= w_timer_next;
            r_seg      <= w_seg_next;
            r_iter     <= w_iter_next;
            r_bank     <= w_bank_next;
            r_pend     <= w_pend_next;
            r_nseg     <= w_nseg_next;
            r_lstart   <= w_lstart_next;
            r_lend     <= w_lend_next;
            r_lcount   <= w_lcount_next;
            r_sync_len <= w_sync_len_next;
        end
    end

    // Output registers: levels follow the state one cycle later, the trigger
    // is computed from the next counter value so it aligns with the counter.
    always_ff @(posedge clk_pll) begin
        if (!reset) begin
            r_chan   <= '0;
            r_att1   <= '0;
            r_att3   <= '0;
            r_sync   <= 1'b0;
            r_active <= 1'b0;
        end else begin
            r_att1 <= pre_att;
            case (r_state)
                S_RUN: begin
                    r_chan   <= w_cur_chan;
                    r_att3   <= w_cur_win ? '0 : post_att;
                    r_active <= 1'b1;
                end
                S_CW: begin
                    r_chan   <= '1;
                    r_att3   <= post_att;
                    r_active <= 1'b0;
                end
                default: begin
                    r_chan   <= '0;
                    r_att3   <= post_att;
                    r_active <= 1'b0;
                end
            endcase
            if (w_state_next == S_CW) begin
                r_sync <= (w_cnt_next >= w_cw_thr);
            end else begin
                r_sync <= (w_cnt_next < w_sync_len_next);
            end
        end
    end

    assign chan_on    = r_chan;
    assign Att1       = r_att1;
    assign Att3       = r_att3;
    assign sync_on    = r_sync;
    assign seq_active = r_active;

endmodule

// File: tb/tb_pulse_seq_engine.sv
// Testbench for pulse_seq_engine. A behavioural model expands the active
// table into a per-period schedule (one entry per cycle, loops unrolled) and
// predicts every output each cycle; directed shots add fixed expectations.
module tb_pulse_seq_engine;
    localparam int CNT_W = 32;
    localparam int DEPTH = 16;
    localparam int AW    = 4;
    localparam int NCH   = 2;
    localparam int ATT_W = 7;

    logic clk_pll = 1'b0;
    always #5 clk_pll = ~clk_pll;

    logic             reset, enable, cw_mode;
    logic [CNT_W-1:0] period, sync_len;
    logic [AW:0]      n_seg;
    logic [AW-1:0]    loop_start, loop_end;
    logic [7:0]       loop_count;
    logic [ATT_W-1:0] pre_att, post_att;
    logic             wr_en;
    logic [AW-1:0]    wr_addr;
    logic [CNT_W-1:0] wr_dur;
    logic [NCH-1:0]   wr_chan;
    logic             wr_win, swap_req;
    logic             swap_ack, sync_on, seq_active;
    logic [NCH-1:0]   chan_on;
    logic [ATT_W-1:0] Att1, Att3;

    pulse_seq_engine #(
        .CNT_W(CNT_W), .DEPTH(DEPTH), .AW(AW), .NCH(NCH), .ATT_W(ATT_W)
    ) dut (
        .clk_pll(clk_pll), .reset(reset), .enable(enable), .cw_mode(cw_mode),
        .period(period), .sync_len(sync_len), .n_seg(n_seg),
        .loop_start(loop_start), .loop_end(loop_end), .loop_count(loop_count),
        .pre_att(pre_att), .post_att(post_att),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_dur(wr_dur), .wr_chan(wr_chan),
        .wr_win(wr_win), .swap_req(swap_req), .swap_ack(swap_ack),
        .sync_on(sync_on), .chan_on(chan_on), .Att1(Att1), .Att3(Att3),
        .seq_active(seq_active)
    );

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_tests++;
        if (obs !== expv) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (model cnt %0d, t=%0t)", tag, obs, expv, m_cnt, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    int  m_dur [2][DEPTH];
    int  m_ch  [2][DEPTH];
    bit  m_win [2][DEPTH];
    int  sched[$];          // per-cycle entry: chan | win<<2
    int  m_cnt = 0, m_kind = 0, m_synclen = 0, n_periods = 0;  // kind: 0 idle, 1 seq, 2 cw
    bit  m_bank = 0, m_pend = 0, m_wrapped = 0;
    logic [31:0] exp_chan, exp_att1, exp_att3, exp_sync, exp_act, exp_ack;

    task automatic add_seg(input bit b, input int s);
        int d;
        d = (m_dur[b][s] == 0) ? 1 : m_dur[b][s];
        for (int i = 0; i < d; i++)
            if (sched.size() <= int'(period) + 1) sched.push_back(m_ch[b][s] | (m_win[b][s] ? 4 : 0));
    endtask

    task automatic build_sched(input bit b, input int n);
        int ls, le, passes;
        bit loop_en;
        ls = int'(loop_start);
        le = int'(loop_end);
        passes = (int'(loop_count) <= 1) ? 1 : int'(loop_count);
        loop_en = (ls <= le) && (le < n);
        sched.delete();
        for (int s = 0; s < n; s++) begin
            add_seg(b, s);
            if (loop_en && s == le)
                for (int p = 1; p < passes; p++)
                    for (int t = ls; t <= le; t++) add_seg(b, t);
        end
    endtask

    task automatic model_step();
        int item, n, thr;
        bit wrap;
        m_wrapped = 0;
        if (reset !== 1'b1) begin
            m_cnt = 0; m_kind = 0; m_bank = 0; m_pend = 0; m_synclen = 0;
            sched.delete();
            exp_ack = 0; exp_chan = 0; exp_att1 = 0; exp_att3 = 0; exp_sync = 0; exp_act = 0;
            return;
        end
        wrap = (m_cnt == int'(period));
        exp_att1 = 32'(pre_att);
        if (m_kind == 2) begin
            exp_chan = 3; exp_att3 = 32'(post_att); exp_act = 0;
        end else if (m_kind == 1 && m_cnt < sched.size()) begin
            item = sched[m_cnt];
            exp_chan = 32'(item & 3);
            exp_att3 = ((item & 4) != 0) ? 0 : 32'(post_att);
            exp_act  = 1;
        end else begin
            exp_chan = 0; exp_att3 = 32'(post_att); exp_act = 0;
        end
        exp_ack = (wrap && (m_pend || swap_req)) ? 1 : 0;
        if (wrap) begin
            if (m_pend || swap_req) m_bank = !m_bank;
            m_pend = 0;
            m_synclen = int'(sync_len);
            m_wrapped = 1;
            n_periods++;
            n = (int'(n_seg) > DEPTH) ? DEPTH : int'(n_seg);
            if (cw_mode) m_kind = 2;
            else if (enable && n > 0) begin
                m_kind = 1;
                build_sched(m_bank, n);
            end else m_kind = 0;
        end else if (swap_req) begin
            m_pend = 1;
        end
        if (wr_en) begin
            m_dur[!m_bank][wr_addr] = int'(wr_dur);
            m_ch[!m_bank][wr_addr]  = int'(wr_chan);
            m_win[!m_bank][wr_addr] = wr_win;
        end
        m_cnt = wrap ? 0 : m_cnt + 1;
        thr = (int'(period) >= m_synclen) ? int'(period) - m_synclen : 0;
        exp_sync = (m_kind == 2) ? 32'(m_cnt >= thr) : 32'(m_cnt < m_synclen);
    endtask

    // One clock: inputs are already driven; check the combinational ack,
    // advance the model, then compare registered outputs at the falling edge.
    task automatic cyc();
        #1;
        model_step();
        check("swap_ack", 32'(swap_ack), exp_ack);
        @(negedge clk_pll);
        check("chan_on", 32'(chan_on), exp_chan);
        check("Att1", 32'(Att1), exp_att1);
        check("Att3", 32'(Att3), exp_att3);
        check("sync_on", 32'(sync_on), exp_sync);
        check("seq_active", 32'(seq_active), exp_act);
        if (m_wrapped)
            $display("[TB] shot %0d: period=%0d kind=%0d bank=%0d sched_len=%0d",
                     n_periods, period, m_kind, m_bank, sched.size());
    endtask

    task automatic sync_to_wrap();
        int k;
        k = 0;
        cyc();
        while (m_cnt != 0 && k < 3000) begin
            cyc();
            k++;
        end
    endtask

    task automatic wr(input int a, input int d, input int ch, input bit w);
        wr_en = 1'b1; wr_addr = AW'(a); wr_dur = CNT_W'(d); wr_chan = NCH'(ch); wr_win = w;
        cyc();
        wr_en = 1'b0;
    endtask

    task automatic rand_fill();
        for (int a = 0; a < DEPTH; a++)
            wr(a, int'($urandom_range(0, 11)), int'($urandom_range(0, 3)), ($urandom_range(0, 3) == 0));
    endtask

    task automatic rand_cfg();
        n_seg      = (AW+1)'($urandom_range(0, 20));
        loop_start = AW'($urandom_range(0, 15));
        loop_end   = AW'($urandom_range(0, 15));
        loop_count = 8'($urandom_range(0, 5));
        sync_len   = CNT_W'($urandom_range(0, 60));
        cw_mode    = ($urandom_range(0, 7) == 0);
        enable     = ($urandom_range(0, 7) != 0);
    endtask

    task automatic hold_reset(input int n);
        reset = 1'b0; wr_en = 1'b0; swap_req = 1'b0;
        repeat (n) cyc();
        reset = 1'b1;
    endtask

    initial begin
        reset = 1'b0; enable = 1'b0; cw_mode = 1'b0; period = 199; sync_len = 30;
        n_seg = 5; loop_start = 0; loop_end = 0; loop_count = 0;
        pre_att = 7'h2a; post_att = 7'h55;
        wr_en = 1'b0; wr_addr = 0; wr_dur = 0; wr_chan = 0; wr_win = 1'b0; swap_req = 1'b0;

        repeat (3) cyc();
        check("rst_chan", 32'(chan_on), 0);
        check("rst_att1", 32'(Att1), 0);
        check("rst_att3", 32'(Att3), 0);
        check("rst_sync", 32'(sync_on), 0);
        reset = 1'b1;

        // Hahn echo
        wr(0, 10, 1, 0); wr(1, 40, 2, 0); wr(2, 20, 1, 0); wr(3, 30, 0, 1); wr(4, 5, 2, 0);
        enable = 1'b1; swap_req = 1'b1; cyc(); swap_req = 1'b0;
        sync_to_wrap();
        for (int c = 1; c <= 199; c++) begin
            cyc();
            check("hahn_ch0", 32'(chan_on[0]), 32'((c <= 10) || (c >= 51 && c <= 70)));
            check("hahn_ch1", 32'(chan_on[1]), 32'((c >= 11 && c <= 50) || (c >= 101 && c <= 105)));
            check("hahn_att3", 32'(Att3), (c >= 71 && c <= 100) ? 0 : 32'h55);
            check("hahn_act", 32'(seq_active), 32'(c <= 105));
            check("hahn_sync", 32'(sync_on), 32'(c < 30));
        end

        // Reset in the middle of segment 1
        repeat (30) cyc();
        enable = 1'b0; period = 299;
        reset = 1'b0;
        for (int i = 0; i < 3; i++) begin
            cyc();
            check("midrst_chan", 32'(chan_on), 0);
            check("midrst_act", 32'(seq_active), 0);
            check("midrst_att1", 32'(Att1), 0);
        end
        reset = 1'b1;

        // CPMG: pi pulse (seg 2) repeated 4 times at 50-cycle spacing
        wr(0, 5, 1, 0); wr(1, 5, 2, 0); wr(2, 10, 1, 0); wr(3, 40, 0, 1); wr(4, 5, 2, 0);
        n_seg = 5; loop_start = 2; loop_end = 3; loop_count = 4; enable = 1'b1;
        swap_req = 1'b1; cyc(); swap_req = 1'b0;
        sync_to_wrap();
        for (int c = 1; c <= 299; c++) begin
            cyc();
            check("cpmg_ch0", 32'(chan_on[0]), 32'((c <= 5) || (c >= 11 && c <= 170 && ((c - 11) % 50) < 10)));
            check("cpmg_ch1", 32'(chan_on[1]), 32'((c >= 6 && c <= 10) || (c >= 211 && c <= 215)));
            check("cpmg_act", 32'(seq_active), 32'(c <= 215));
        end

        // CW mode, then back to IDLE with enable low
        reset = 1'b0; period = 999; cw_mode = 1'b1; sync_len = 50;
        repeat (2) cyc();
        reset = 1'b1;
        sync_to_wrap();
        for (int c = 1; c <= 999; c++) begin
            cyc();
            check("cw_chan", 32'(chan_on), 3);
            check("cw_sync", 32'(sync_on), 32'(c >= 949));
        end
        cw_mode = 1'b0; enable = 1'b0;
        sync_to_wrap();
        for (int c = 1; c <= 10; c++) begin
            cyc();
            check("idle_chan", 32'(chan_on), 0);
        end

        // Randomised shots: both banks filled, random config, writes, swaps, resets
        for (int s = 0; s < 20; s++) begin
            reset = 1'b0; enable = 1'b0; cw_mode = 1'b0;
            period = CNT_W'($urandom_range(40, 200));
            repeat (2) cyc();
            reset = 1'b1;
            rand_fill();
            swap_req = 1'b1; cyc(); swap_req = 1'b0;
            rand_cfg();
            sync_to_wrap();
            rand_fill();
            for (int i = 0; i < 3 * (int'(period) + 1); i++) begin
                reset    = ($urandom_range(0, 399) != 0);
                wr_en    = reset && ($urandom_range(0, 3) == 0);
                wr_addr  = AW'($urandom_range(0, 15));
                wr_dur   = CNT_W'($urandom_range(0, 11));
                wr_chan  = NCH'($urandom_range(0, 3));
                wr_win   = ($urandom_range(0, 3) == 0);
                swap_req = ($urandom_range(0, 149) == 0);
                if ($urandom_range(0, 199) == 0) rand_cfg();
                if ($urandom_range(0, 19) == 0) pre_att = ATT_W'($urandom_range(0, 127));
                if ($urandom_range(0, 19) == 0) post_att = ATT_W'($urandom_range(0, 127));
                cyc();
            end
            wr_en = 1'b0; swap_req = 1'b0; reset = 1'b1;
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/pulse_seq_engine.md
Name: pulse_seq_engine

Overview:
Table-driven, parametrised pulse sequencer that replaces the fixed Hahn/CPMG state machine with a programmable segment table. It drives NCH switch channels, the two attenuators and the scope trigger. Timing comes from a free-running period counter on the 200 MHz PLL clock. A double-buffered table, software-defined loop region and CW mode allow arbitrary echo trains and nutation sequences without a rebuild.

Parameters:
CNT_W, 32, width of period/duration counters
DEPTH, 16, segments per table bank (power of 2)
AW, 4, segment address width (log2 DEPTH)
NCH, 2, number of switch output channels
ATT_W, 7, attenuator control width

Ports:
clk_pll  in  1  200 MHz PLL clock
reset  in  1  synchronous, active-low reset
enable  in  1  run sequencer; sampled only at period wrap
cw_mode  in  1  1 = CW mode, 0 = pulsed mode
period  in  CNT_W  counter runs 0..period (period+1 cycles)
sync_len  in  CNT_W  scope trigger width in cycles
n_seg  in  AW+1  number of valid segments in active bank (0..DEPTH)
loop_start  in  AW  first segment of repeat region
loop_end  in  AW  last segment of repeat region
loop_count  in  8  passes through repeat region (0 or 1 = once)
pre_att  in  ATT_W  pump attenuation
post_att  in  ATT_W  second-attenuator setting outside signal windows
wr_en  in  1  write one segment into shadow bank
wr_addr  in  AW  segment address
wr_dur  in  CNT_W  segment duration in cycles (0 treated as 1)
wr_chan  in  NCH  channel levels during segment
wr_win  in  1  1 = signal window (Att3 forced to 0)
swap_req  in  1  request shadow/active swap at next wrap
swap_ack  out  1  1-cycle pulse when swap takes effect
sync_on  out  1  scope trigger
chan_on  out  NCH  switch outputs (bit 0 = pulse switch, bit 1 = block switch)
Att1  out  ATT_W  main attenuator
Att3  out  ATT_W  second attenuator
seq_active  out  1  high while a segment is executing

Behaviour:
- Reset (reset==0 at a clock edge): counter=0, state=IDLE, seg_idx=0, iter=0, active bank=0, swap pending cleared. All outputs 0. Table RAM contents are not cleared.
- Counter: counter <= (counter < period) ? counter+1 : 0. "Wrap" is the cycle in which counter==period. It runs in every state except reset.
- States: IDLE, RUN, HOLD, CW.
- At wrap:
  - cw_mode=1 -> CW.
  - else enable=1 and n_seg>0 -> RUN with seg_idx=0, iter=0, seg timer loaded with dur[0].
  - else -> IDLE.
- RUN:
  - chan_on and window flag come from active_bank[seg_idx].
  - Timer decrements each cycle. On expiry the next index is chosen:
    - seg_idx==loop_end, loop_start<=loop_end, and iter+1<loop_count -> go to loop_start, iter++.
    - else if seg_idx+1 < n_seg -> seg_idx+1.
    - else -> HOLD.
- HOLD: chan_on=0, Att3=post_att, until wrap.
- IDLE: chan_on=0, Att3=post_att, sync_on still generated.
- Truncation: if the sequence has not finished at wrap, it is truncated; the new period restarts cleanly from segment 0.
- Output latency: all outputs are registered. The segment-0 level appears on the cycle after counter==0. Segment k with duration d holds its outputs for exactly d cycles.
- Att1 <= pre_att in all states.
- Att3:
  - pulsed mode: 0 during window segments, else post_att.
  - CW mode: Att3=post_att.
- sync_on:
  - pulsed mode (RUN/HOLD/IDLE): 1 while counter < sync_len.
  - CW mode: 1 while counter >= period - sync_len (saturating at 0).
- CW: chan_on all ones.
- Writes: wr_en writes only the shadow bank, every cycle, in any state. A write to the active bank is impossible by construction.
- Swap:
  - swap_req sets swap-pending; the swap executes at the next wrap and swap_ack pulses on that cycle.
  - swap_req in the wrap cycle itself is applied at that wrap.
  - Repeated requests before the wrap collapse to one swap.
- Config inputs n_seg, loop_*, sync_len, cw_mode and enable are latched at wrap. period is used live.
- Out-of-range values:
  - n_seg > DEPTH is clamped to DEPTH.
  - loop_end >= n_seg disables looping.
- Reset mid-RUN: outputs drop to 0 on the next edge. The next sequence starts after the first wrap following reset release.

Test Plan:
- Hahn echo: bank {dur 10 ch=01, 40 ch=10, 20 ch=01, 30 win, 5 ch=10}, n_seg=5, period=199 -> chan_on[0] high counter 1-10 and 51-70; Att3=0 counter 71-100; sync 1 for counter<sync_len=30; HOLD after counter 105.
- CPMG loop: loop_start=2, loop_end=3, loop_count=4 -> pi pulse repeated 4 times at 50-cycle spacing; segment 4 executes once after the loop; seq_active low after the last segment.
- Truncation: total duration 300, period=199 -> outputs cut at wrap; segment 0 restarts at counter 1 of each period, with no leftover state.
- Swap: write new table while running, pulse swap_req at counter 50 -> old sequence completes; swap_ack at counter==period; new pattern appears from the next period. Writes after a swap target the other bank.
- CW/enable: cw_mode=1, period=999, sync_len=50 -> chan_on all 1, sync_on high counter 949-999. enable=0 -> IDLE at next wrap with chan_on=0.
- Reset: assert reset=0 mid-segment for 3 cycles -> all outputs 0 and counter 0. dur=0 entry behaves as 1 cycle; n_seg=0 gives only sync.
